// File: rtl/shift_issue_stage.sv
// Two-stage EX front-end for RV32I shift instructions: decode into S1 registers that
// feed an external combinational shifter, then capture its result into S2 for hand-off.
module shift_issue_stage #(
    parameter int XLEN  = 32,
    parameter int RD_W  = 5,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  in_inst,
    input  logic [XLEN-1:0]  in_rs1,
    input  logic [XLEN-1:0]  in_rs2,
    output logic [XLEN-1:0]  sh_data,
    output logic [4:0]       sh_shamt,
    output logic             sh_l_or_r,
    output logic             sh_a_or_l,
    input  logic [XLEN-1:0]  sh_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [RD_W-1:0]  out_rd,
    output logic             out_illegal,
    output logic [CNT_W-1:0] retired_cnt
);

    localparam logic [6:0] OP_REG  = 7'b0110011;
    localparam logic [6:0] OP_IMM  = 7'b0010011;
    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ARITH = 7'b0100000;

    // Valid/ready: a transfer happens on a side when valid && ready at the rising
    // edge; ready never depends on the same side's valid, and a stage holding an op
    // keeps its payload stable until that op transfers onward.

    logic             s1_valid_q, s1_valid_d;
    logic             s1_illegal_q, s1_illegal_d;
    logic [RD_W-1:0]  s1_rd_q, s1_rd_d;
    logic [XLEN-1:0]  sh_data_q, sh_data_d;
    logic [4:0]       sh_shamt_q, sh_shamt_d;
    logic             sh_l_or_r_q, sh_l_or_r_d;
    logic             sh_a_or_l_q, sh_a_or_l_d;

    logic             s2_valid_q, s2_valid_d;
    logic [XLEN-1:0]  out_result_q, out_result_d;
    logic [RD_W-1:0]  out_rd_q, out_rd_d;
    logic             out_illegal_q, out_illegal_d;
    logic [CNT_W-1:0] retired_cnt_q, retired_cnt_d;

    logic             s2_ready, s1_ready;
    logic             in_fire, s1_adv, out_fire;

    logic [6:0]       opcode, f7;
    logic [2:0]       f3;
    logic             dec_legal;
    logic             dec_l_or_r, dec_a_or_l;
    logic [4:0]       dec_shamt_src;
    logic             rs2_unused;

    assign opcode = in_inst[6:0];
    assign f3     = in_inst[14:12];
    assign f7     = in_inst[31:25];

    // Only rs2[4:0] carries the shift amount; the upper bits are architecturally ignored.
    assign rs2_unused = ^in_rs2[XLEN-1:5];

    always_comb begin
        dec_legal     = 1'b0;
        dec_l_or_r    = 1'b0;
        dec_a_or_l    = 1'b0;
        dec_shamt_src = (opcode == OP_REG) ? in_rs2[4:0] : in_inst[24:20];
        if (opcode == OP_REG || opcode == OP_IMM) begin
            if (f3 == 3'b001 && f7 == F7_ZERO) begin
                dec_legal  = 1'b1;
                dec_l_or_r = 1'b1;
            end else if (f3 == 3'b101 && f7 == F7_ZERO) begin
                dec_legal  = 1'b1;
            end else if (f3 == 3'b101 && f7 == F7_ARITH) begin
                dec_legal  = 1'b1;
                dec_a_or_l = 1'b1;
            end
        end
    end

    assign s2_ready = !s2_valid_q || out_ready;
    assign s1_ready = !s1_valid_q || s2_ready;
    assign in_fire  = in_valid && s1_ready;
    assign s1_adv   = s1_valid_q && s2_ready;
    assign out_fire = s2_valid_q && out_ready;

    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_illegal_d = s1_illegal_q;
        s1_rd_d      = s1_rd_q;
        sh_data_d    = sh_data_q;
        sh_shamt_d   = sh_shamt_q;
        sh_l_or_r_d  = sh_l_or_r_q;
        sh_a_or_l_d  = sh_a_or_l_q;
        if (in_fire) begin
            s1_illegal_d = !dec_legal;
            s1_rd_d      = in_inst[11:7];
            sh_data_d    = dec_legal ? in_rs1 : '0;
            sh_shamt_d   = dec_legal ? dec_shamt_src : 5'd0;
            sh_l_or_r_d  = dec_legal && dec_l_or_r;
            sh_a_or_l_d  = dec_legal && dec_a_or_l;
        end
        // Flush outranks a same-cycle accept; stale payload is harmless once invalid.
        if (flush) begin
            s1_valid_d = 1'b0;
        end else if (in_fire) begin
            s1_valid_d = 1'b1;
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end
    end

    always_comb begin
        s2_valid_d    = s2_valid_q;
        out_result_d  = out_result_q;
        out_rd_d      = out_rd_q;
        out_illegal_d = out_illegal_q;
        if (s1_adv) begin
            out_result_d  = s1_illegal_q ? '0 : sh_result;
            out_rd_d      = s1_rd_q;
            out_illegal_d = s1_illegal_q;
        end
        if (flush) begin
            s2_valid_d = 1'b0;
        end else if (s1_adv) begin
            s2_valid_d = 1'b1;
        end else if (out_fire) begin
            s2_valid_d = 1'b0;
        end
        retired_cnt_d = retired_cnt_q
                        + {{(CNT_W-1){1'b0}}, (out_fire && !out_illegal_q)};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q    <= 1'b0;
            s1_illegal_q  <= 1'b0;
            s1_rd_q       <= '0;
            sh_data_q     <= '0;
            sh_shamt_q    <= '0;
            sh_l_or_r_q   <= 1'b0;
            sh_a_or_l_q   <= 1'b0;
            s2_valid_q    <= 1'b0;
            out_result_q  <= '0;
            out_rd_q      <= '0;
            out_illegal_q <= 1'b0;
            retired_cnt_q <= '0;
        end else begin
            s1_valid_q    <= s1_valid_d;
            s1_illegal_q  <= s1_illegal_d;
            s1_rd_q       <= s1_rd_d;
            sh_data_q     <= sh_data_d;
            sh_shamt_q    <= sh_shamt_d;
            sh_l_or_r_q   <= sh_l_or_r_d;
            sh_a_or_l_q   <= sh_a_or_l_d;
            s2_valid_q    <= s2_valid_d;
            out_result_q  <= out_result_d;
            out_rd_q      <= out_rd_d;
            out_illegal_q <= out_illegal_d;
            retired_cnt_q <= retired_cnt_d;
        end
    end

    assign in_ready    = s1_ready;
    assign sh_data     = sh_data_q;
    assign sh_shamt    = sh_shamt_q;
    assign sh_l_or_r   = sh_l_or_r_q;
    assign sh_a_or_l   = sh_a_or_l_q;
    assign out_valid   = s2_valid_q;
    assign out_result  = out_result_q;
    assign out_rd      = out_rd_q;
    assign out_illegal = out_illegal_q;
    assign retired_cnt = retired_cnt_q;

endmodule

// File: tb/tb_shift_issue_stage.sv
// Bench for shift_issue_stage: models the external shifter, drives a vector table
// through the pipe and checks every hand-off against an expected-result queue.
module tb_shift_issue_stage;

    localparam logic [6:0] OP_REG = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_inst = '0;
    logic [31:0] in_rs1 = '0;
    logic [31:0] in_rs2 = '0;
    logic [31:0] sh_data;
    logic [4:0]  sh_shamt;
    logic        sh_l_or_r;
    logic        sh_a_or_l;
    logic [31:0] sh_result;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_result;
    logic [4:0]  out_rd;
    logic        out_illegal;
    logic [31:0] retired_cnt;

    shift_issue_stage dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_inst(in_inst), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .sh_data(sh_data), .sh_shamt(sh_shamt),
        .sh_l_or_r(sh_l_or_r), .sh_a_or_l(sh_a_or_l),
        .sh_result(sh_result),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_rd(out_rd), .out_illegal(out_illegal),
        .retired_cnt(retired_cnt)
    );

    // External combinational shifter.
    always_comb begin
        if (sh_l_or_r)
            sh_result = sh_data << sh_shamt;
        else if (sh_a_or_l)
            sh_result = $unsigned($signed(sh_data) >>> sh_shamt);
        else
            sh_result = sh_data >> sh_shamt;
    end

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] res;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic        ill;
        logic        lr;
        logic        al;
    } vec_t;

    vec_t        vecs[11];
    logic [37:0] exp_q[$];
    logic [37:0] drv_exp = '0;
    logic        last_accept = 1'b0;
    logic        done = 1'b0;
    int          tests = 0;
    int          fails = 0;
    logic [31:0] exp_retired = '0;

    function automatic logic [31:0] mk(input logic [6:0] f7, input logic [4:0] r2,
                                       input logic [2:0] f3, input logic [4:0] rd,
                                       input logic [6:0] op);
        return {f7, r2, 5'd10, f3, rd, op};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Scoreboard: push on accepted input, pop and compare on output hand-off.
    always @(negedge clk) begin
        if (rst_n) begin
            last_accept = 1'b0;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", {27'd0, out_rd}, 32'hFFFF_FFFF);
                end else begin
                    logic [37:0] e;
                    e = exp_q.pop_front();
                    chk("retired_before", retired_cnt, exp_retired);
                    chk("out_result", out_result, e[31:0]);
                    chk("out_rd", {27'd0, out_rd}, {27'd0, e[36:32]});
                    chk("out_illegal", {31'd0, out_illegal}, {31'd0, e[37]});
                    if (!e[37]) exp_retired = exp_retired + 1;
                end
            end
            if (flush) begin
                exp_q.delete();
            end else if (in_valid && in_ready) begin
                exp_q.push_back(drv_exp);
                last_accept = 1'b1;
            end
        end
    end

    task automatic drive(input int i);
        in_valid = 1'b1;
        in_inst  = vecs[i].inst;
        in_rs1   = vecs[i].rs1;
        in_rs2   = vecs[i].rs2;
        drv_exp  = {vecs[i].ill, vecs[i].rd, vecs[i].res};
    endtask

    task automatic wait_accept(input string nm);
        int n;
        n = 0;
        forever begin
            @(posedge clk); #1;
            if (last_accept) break;
            n++;
            if (n > 50) begin
                chk(nm, 32'd0, 32'd1);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic send(input int i);
        drive(i);
        wait_accept("accept_timeout");
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_done", {31'd0, (n < 50)}, 32'd1);
    endtask

    task automatic check_s1(input int i);
        chk("sh_data", sh_data, vecs[i].ill ? 32'd0 : vecs[i].rs1);
        chk("sh_shamt", {27'd0, sh_shamt}, {27'd0, vecs[i].shamt});
        chk("sh_l_or_r", {31'd0, sh_l_or_r}, {31'd0, vecs[i].lr});
        chk("sh_a_or_l", {31'd0, sh_a_or_l}, {31'd0, vecs[i].al});
    endtask

    task automatic check_reset_vals();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_sh_data", sh_data, 32'd0);
        chk("rst_sh_ctl", {25'd0, sh_shamt, sh_l_or_r, sh_a_or_l}, 32'd0);
        chk("rst_out_result", out_result, 32'd0);
        chk("rst_out_rd_ill", {26'd0, out_rd, out_illegal}, 32'd0);
        chk("rst_retired", retired_cnt, 32'd0);
    endtask

    initial begin
        logic [31:0] base;
        vecs[0]  = '{mk(7'h00, 5'd31, 3'b001, 5'd1, OP_IMM), 32'h0000_0001, 32'h0,
                     32'h8000_0000, 5'd1, 5'd31, 1'b0, 1'b1, 1'b0};
        vecs[1]  = '{mk(7'h20, 5'd4, 3'b101, 5'd2, OP_IMM), 32'h8000_00F0, 32'h0,
                     32'hF800_000F, 5'd2, 5'd4, 1'b0, 1'b0, 1'b1};
        vecs[2]  = '{mk(7'h00, 5'd4, 3'b101, 5'd3, OP_IMM), 32'h8000_00F0, 32'h0,
                     32'h0800_000F, 5'd3, 5'd4, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{mk(7'h20, 5'd11, 3'b101, 5'd4, OP_REG), 32'hFFFF_0000, 32'hFFFF_FFE8,
                     32'hFFFF_FF00, 5'd4, 5'd8, 1'b0, 1'b0, 1'b1};
        vecs[4]  = '{mk(7'h00, 5'd11, 3'b001, 5'd5, OP_REG), 32'h1234_5678, 32'h0000_0024,
                     32'h2345_6780, 5'd5, 5'd4, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{mk(7'h00, 5'd11, 3'b101, 5'd6, OP_REG), 32'h8000_0000, 32'hFFFF_FFFF,
                     32'h0000_0001, 5'd6, 5'd31, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{32'h00B5_0533, 32'h0000_1234, 32'h0000_0005,
                     32'h0, 5'd10, 5'd0, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{mk(7'h01, 5'd3, 3'b001, 5'd7, OP_IMM), 32'h0000_FFFF, 32'h0,
                     32'h0, 5'd7, 5'd0, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{mk(7'h00, 5'd0, 3'b001, 5'd8, OP_IMM), 32'hDEAD_BEEF, 32'h0,
                     32'hDEAD_BEEF, 5'd8, 5'd0, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{mk(7'h20, 5'd11, 3'b001, 5'd9, OP_REG), 32'h0000_00FF, 32'h3,
                     32'h0, 5'd9, 5'd0, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{mk(7'h20, 5'd31, 3'b101, 5'd11, OP_IMM), 32'h8000_0000, 32'h0,
                     32'hFFFF_FFFF, 5'd11, 5'd31, 1'b0, 1'b0, 1'b1};

        // Reset values while held in reset.
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Latency: S1 after the accept edge, output valid one edge later, taken at the next.
        send(0);
        chk("lat_s1_only", {31'd0, out_valid}, 32'd0);
        check_s1(0);
        @(posedge clk); #1;
        chk("lat_out_valid", {31'd0, out_valid}, 32'd1);
        chk("lat_out_result", out_result, 32'h8000_0000);
        drain();

        // Each vector alone: decode into S1, then result and counter.
        for (int i = 0; i < 11; i++) begin
            send(i);
            check_s1(i);
            drain();
            chk("retired_after_op", retired_cnt, exp_retired);
        end

        // Back-pressure: two accepts fill the pipe, third op waits, outputs hold.
        out_ready = 1'b0;
        base = exp_retired;
        send(4);
        send(5);
        chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
        drive(8);
        repeat (3) begin
            @(posedge clk); #1;
            chk("stall_in_ready_hold", {31'd0, in_ready}, 32'd0);
            chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
            chk("stall_out_result", out_result, vecs[4].res);
            chk("stall_out_rd", {27'd0, out_rd}, {27'd0, vecs[4].rd});
        end
        out_ready = 1'b1;
        wait_accept("stall_release");
        send(10);
        drain();
        chk("stall_retired", retired_cnt, base + 32'd4);

        // Flush with both stages full, the output draining and a new op offered.
        out_ready = 1'b0;
        send(1);
        send(2);
        drive(3);
        flush = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
        repeat (3) begin
            @(posedge clk); #1;
            chk("flush_no_emerge", {31'd0, out_valid}, 32'd0);
        end
        chk("flush_retired", retired_cnt, exp_retired);

        // Streaming with random downstream back-pressure.
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 11; i++) send(i);
                for (int i = 10; i >= 0; i--) send(i);
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        drain();
        chk("stream_retired", retired_cnt, exp_retired);

        // Asynchronous reset in the middle of traffic.
        out_ready = 1'b0;
        send(0);
        send(3);
        drive(5);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals();
        exp_q.delete();
        exp_retired = '0;
        in_valid = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        send(2);
        drain();
        chk("post_reset_retired", retired_cnt, 32'd1);

        chk("queue_empty", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
